// File: rtl/gci_std_display_char_render.sv
// Renders one 8x14 font glyph into the VRAM pixel-write port, one pixel per accepted write.
// Optional feature macro: GCI_STD_DISPLAY_RENDER_TRANSPARENT_EN (skip background pixels).
module gci_std_display_char_render #(
    parameter int P_H_WIDTH  = 640,
    parameter int P_V_HEIGHT = 480,
    parameter int P_COLOR_W  = 16,
    parameter int P_ADDR_W   = 19
) (
    input  logic                 iCLOCK,
    input  logic                 iRESET_SYNC,
    input  logic                 iREQ,
    output logic                 oBUSY,
    input  logic [6:0]           iCHAR,
    input  logic [6:0]           iPOS_X,
    input  logic [5:0]           iPOS_Y,
    input  logic [P_COLOR_W-1:0] iFG_COLOR,
    input  logic [P_COLOR_W-1:0] iBG_COLOR,
`ifdef GCI_STD_DISPLAY_RENDER_TRANSPARENT_EN
    input  logic                 iTRANSPARENT,
`endif
    output logic                 oDONE,
    output logic [6:0]           oFONT_ADDR,
    input  logic [111:0]         iFONT_DATA,
    output logic                 oWR_REQ,
    input  logic                 iWR_BUSY,
    output logic [P_ADDR_W-1:0]  oWR_ADDR,
    output logic [P_COLOR_W-1:0] oWR_DATA
);

    localparam logic [6:0]          AREA_H     = 7'(P_H_WIDTH / 8);
    localparam logic [5:0]          AREA_V     = 6'(P_V_HEIGHT / 14);
    localparam logic [P_ADDR_W-1:0] ROW_PITCH  = P_ADDR_W'(P_H_WIDTH);
    localparam logic [P_ADDR_W-1:0] CHAR_PITCH = P_ADDR_W'(14 * P_H_WIDTH);

    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_DRAW, ST_DONE} state_t;

    state_t                 state_q, state_d;
    logic [6:0]             char_q, char_d;
    logic [6:0]             pos_x_q, pos_x_d;
    logic [5:0]             pos_y_q, pos_y_d;
    logic [P_COLOR_W-1:0]   fg_q, fg_d;
    logic [P_COLOR_W-1:0]   bg_q, bg_d;
    logic [111:0]           glyph_q, glyph_d;
    logic [6:0]             idx_q, idx_d;
    logic [P_ADDR_W-1:0]    row_base_q, row_base_d;
    logic                   wr_req_q, wr_req_d;
    logic [P_ADDR_W-1:0]    wr_addr_q, wr_addr_d;
    logic [P_COLOR_W-1:0]   wr_data_q, wr_data_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [P_ADDR_W-1:0]    base_addr;
    logic                   in_range;
    logic                   last_pixel;

`ifdef GCI_STD_DISPLAY_RENDER_TRANSPARENT_EN
    logic                   trans_q, trans_d;
    logic [P_ADDR_W-1:0]    base_q, base_d;
    logic [7:0]             nxt;

    // Returns {found, index} of the first drawable pixel at or after start; lowest index wins.
    function automatic logic [7:0] find_next(input logic [111:0] g, input logic [6:0] start,
                                             input logic skip_bg);
        logic [7:0] res;
        res = 8'd0;
        for (int i = 111; i >= 0; i--) begin
            if ((7'(i) >= start) && (g[111 - i] || !skip_bg)) begin
                res = {1'b1, 7'(i)};
            end
        end
        return res;
    endfunction
`endif

    always_comb begin
        base_addr = P_ADDR_W'(pos_y_q) * CHAR_PITCH + P_ADDR_W'({pos_x_q, 3'b000});
        in_range  = (pos_x_q < AREA_H) && (pos_y_q < AREA_V);
    end

    always_comb begin
        state_d    = state_q;
        char_d     = char_q;
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        fg_d       = fg_q;
        bg_d       = bg_q;
        glyph_d    = glyph_q;
        idx_d      = idx_q;
        row_base_d = row_base_q;
        wr_req_d   = wr_req_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        last_pixel = 1'b0;
`ifdef GCI_STD_DISPLAY_RENDER_TRANSPARENT_EN
        trans_d    = trans_q;
        base_d     = base_q;
        nxt        = 8'd0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (iREQ) begin
                    char_d  = iCHAR;
                    pos_x_d = iPOS_X;
                    pos_y_d = iPOS_Y;
                    fg_d    = iFG_COLOR;
                    bg_d    = iBG_COLOR;
`ifdef GCI_STD_DISPLAY_RENDER_TRANSPARENT_EN
                    trans_d = iTRANSPARENT;
`endif
                    busy_d  = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                glyph_d = iFONT_DATA;
                state_d = ST_DRAW;
                // An out-of-range position passes through DRAW with no write pending.
                wr_req_d = 1'b0;
                if (in_range) begin
`ifdef GCI_STD_DISPLAY_RENDER_TRANSPARENT_EN
                    nxt        = find_next(iFONT_DATA, 7'd0, trans_q);
                    wr_req_d   = nxt[7];
                    idx_d      = nxt[6:0];
                    base_d     = base_addr;
                    row_base_d = base_addr + P_ADDR_W'(nxt[6:3]) * ROW_PITCH;
`else
                    wr_req_d   = 1'b1;
                    idx_d      = 7'd0;
                    row_base_d = base_addr;
`endif
                    wr_addr_d  = row_base_d + P_ADDR_W'(idx_d[2:0]);
                    wr_data_d  = glyph_d[7'd111 - idx_d] ? fg_q : bg_q;
                end
            end
            ST_DRAW: begin
                if (!wr_req_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if (!iWR_BUSY) begin
`ifdef GCI_STD_DISPLAY_RENDER_TRANSPARENT_EN
                    nxt        = find_next(glyph_q, idx_q + 7'd1, trans_q);
                    last_pixel = !nxt[7];
`else
                    last_pixel = (idx_q == 7'd111);
`endif
                    if (last_pixel) begin
                        wr_req_d = 1'b0;
                        state_d  = ST_DONE;
                        done_d   = 1'b1;
                    end else begin
`ifdef GCI_STD_DISPLAY_RENDER_TRANSPARENT_EN
                        idx_d      = nxt[6:0];
                        row_base_d = base_q + P_ADDR_W'(nxt[6:3]) * ROW_PITCH;
`else
                        idx_d = idx_q + 7'd1;
                        if (idx_q[2:0] == 3'd7) begin
                            row_base_d = row_base_q + ROW_PITCH;
                        end
`endif
                        wr_addr_d = row_base_d + P_ADDR_W'(idx_d[2:0]);
                        wr_data_d = glyph_q[7'd111 - idx_d] ? fg_q : bg_q;
                    end
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            state_q    <= ST_IDLE;
            char_q     <= '0;
            pos_x_q    <= '0;
            pos_y_q    <= '0;
            fg_q       <= '0;
            bg_q       <= '0;
            glyph_q    <= '0;
            idx_q      <= '0;
            row_base_q <= '0;
            wr_req_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef GCI_STD_DISPLAY_RENDER_TRANSPARENT_EN
            trans_q    <= 1'b0;
            base_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            char_q     <= char_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            fg_q       <= fg_d;
            bg_q       <= bg_d;
            glyph_q    <= glyph_d;
            idx_q      <= idx_d;
            row_base_q <= row_base_d;
            wr_req_q   <= wr_req_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef GCI_STD_DISPLAY_RENDER_TRANSPARENT_EN
            trans_q    <= trans_d;
            base_q     <= base_d;
`endif
        end
    end

    assign oBUSY      = busy_q;
    assign oDONE      = done_q;
    assign oFONT_ADDR = char_q;
    assign oWR_REQ    = wr_req_q;
    assign oWR_ADDR   = wr_addr_q;
    assign oWR_DATA   = wr_data_q;

endmodule
